// File: rtl/tile_row_fetcher_if.sv
// Bundle of the descriptor, memory read and tile-buffer stream signals of tile_row_fetcher.
// The slave modport is the fetcher's view; master is the surrounding system's view.
interface tile_row_fetcher_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DIM_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base_addr;
    logic [DIM_WIDTH-1:0]  cmd_stride_bytes;
    logic [DIM_WIDTH-1:0]  cmd_row_bytes;
    logic [DIM_WIDTH-1:0]  cmd_rows;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;
    logic [DIM_WIDTH-1:0]  rd_req_len;

    logic                  rd_data_valid;
    logic                  rd_data_ready;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_row_last;
    logic                  out_tile_last;

    logic                  busy;
    logic                  done;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_stride_bytes, cmd_row_bytes, cmd_rows,
        input  cmd_ready,
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready,
        output rd_data_valid, rd_data,
        input  rd_data_ready,
        input  out_valid, out_data, out_row_last, out_tile_last,
        output out_ready,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_stride_bytes, cmd_row_bytes, cmd_rows,
        output cmd_ready,
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready,
        input  rd_data_valid, rd_data,
        output rd_data_ready,
        output out_valid, out_data, out_row_last, out_tile_last,
        input  out_ready,
        output busy, done
    );
endinterface

// File: rtl/tile_row_fetcher.sv
// Strided tile fetcher: splits each row of a region into bounded read bursts and streams
// the returned beats downstream, tagged with row and tile boundaries.
module tile_row_fetcher #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DIM_WIDTH       = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_BURST_BYTES = 256
) (
    input logic               clk,
    input logic               rst,
    tile_row_fetcher_if.slave bus
);
    localparam int unsigned          BPB        = DATA_WIDTH / 8;
    localparam int unsigned          BEAT_SHIFT = $clog2(BPB);
    localparam logic [DIM_WIDTH-1:0] LOW_MASK   = DIM_WIDTH'(BPB - 1);
    localparam logic [DIM_WIDTH-1:0] MAX_LEN    = DIM_WIDTH'(MAX_BURST_BYTES);
    localparam logic [DIM_WIDTH-1:0] DIM_ONE    = DIM_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [DIM_WIDTH-1:0]  stride_q, stride_d;
    logic [DIM_WIDTH-1:0]  rb_q, rb_d;
    logic [DIM_WIDTH-1:0]  rows_q, rows_d;
    logic [DIM_WIDTH-1:0]  bpr_q, bpr_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [DIM_WIDTH-1:0]  req_off_q, req_off_d;
    logic [DIM_WIDTH-1:0]  req_row_q, req_row_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DIM_WIDTH-1:0]  req_len_q, req_len_d;
    logic [DIM_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DIM_WIDTH-1:0]  row_cnt_q, row_cnt_d;

    logic [DIM_WIDTH-1:0]  cmd_rb, first_len, next_len, row_len;
    logic [ADDR_WIDTH-1:0] next_row_addr;
    logic                  data_active, cmd_hs, req_hs, out_hs, out_valid;
    logic                  row_last, tile_last;

    function automatic logic [DIM_WIDTH-1:0] clip_len(input logic [DIM_WIDTH-1:0] bytes);
        return (bytes > MAX_LEN) ? MAX_LEN : bytes;
    endfunction

    assign cmd_rb        = bus.cmd_row_bytes & ~LOW_MASK;
    assign first_len     = clip_len(cmd_rb);
    assign next_len      = clip_len(rb_q - req_off_q);
    assign row_len       = clip_len(rb_q);
    assign next_row_addr = row_addr_q + ADDR_WIDTH'(stride_q);

    assign data_active = (state_q == StRun) || (state_q == StDrain);
    assign cmd_hs      = bus.cmd_valid && (state_q == StIdle);
    assign req_hs      = req_valid_q && bus.rd_req_ready;
    assign out_valid   = data_active && bus.rd_data_valid;
    assign out_hs      = out_valid && bus.out_ready;
    assign row_last    = (beat_cnt_q == bpr_q - DIM_ONE);
    assign tile_last   = row_last && (row_cnt_q == rows_q - DIM_ONE);

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.rd_req_valid  = req_valid_q;
    assign bus.rd_req_addr   = req_addr_q;
    assign bus.rd_req_len    = req_len_q;
    assign bus.rd_data_ready = data_active && bus.out_ready;
    assign bus.out_valid     = out_valid;
    assign bus.out_data      = bus.rd_data;
    assign bus.out_row_last  = out_valid && row_last;
    assign bus.out_tile_last = out_valid && tile_last;
    assign bus.busy          = (state_q != StIdle);
    assign bus.done          = (state_q == StDone);

    always_comb begin
        state_d     = state_q;
        stride_d    = stride_q;
        rb_d        = rb_q;
        rows_d      = rows_q;
        bpr_d       = bpr_q;
        row_addr_d  = row_addr_q;
        req_off_d   = req_off_q;
        req_row_d   = req_row_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_len_d   = req_len_q;
        beat_cnt_d  = beat_cnt_q;
        row_cnt_d   = row_cnt_q;

        if (out_hs) begin
            if (row_last) begin
                beat_cnt_d = '0;
                row_cnt_d  = row_cnt_q + DIM_ONE;
            end else begin
                beat_cnt_d = beat_cnt_q + DIM_ONE;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (cmd_hs) begin
                    stride_d   = bus.cmd_stride_bytes;
                    rb_d       = cmd_rb;
                    rows_d     = bus.cmd_rows;
                    bpr_d      = cmd_rb >> BEAT_SHIFT;
                    beat_cnt_d = '0;
                    row_cnt_d  = '0;
                    if (cmd_rb == '0 || bus.cmd_rows == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StRun;
                        req_valid_d = 1'b1;
                        req_addr_d  = bus.cmd_base_addr;
                        req_len_d   = first_len;
                        req_off_d   = first_len;
                        req_row_d   = '0;
                        row_addr_d  = bus.cmd_base_addr;
                    end
                end
            end
            StRun: begin
                // req_off_q holds the offset just past the chunk currently presented.
                if (req_hs) begin
                    if (req_off_q != rb_q) begin
                        req_addr_d = row_addr_q + ADDR_WIDTH'(req_off_q);
                        req_len_d  = next_len;
                        req_off_d  = req_off_q + next_len;
                    end else if (req_row_q == rows_q - DIM_ONE) begin
                        req_valid_d = 1'b0;
                        state_d     = StDrain;
                    end else begin
                        row_addr_d = next_row_addr;
                        req_addr_d = next_row_addr;
                        req_len_d  = row_len;
                        req_off_d  = row_len;
                        req_row_d  = req_row_q + DIM_ONE;
                    end
                end
                if (out_hs && tile_last) begin
                    state_d     = StDone;
                    req_valid_d = 1'b0;
                end
            end
            StDrain: begin
                if (out_hs && tile_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            stride_q    <= '0;
            rb_q        <= '0;
            rows_q      <= '0;
            bpr_q       <= '0;
            row_addr_q  <= '0;
            req_off_q   <= '0;
            req_row_q   <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            rb_q        <= rb_d;
            rows_q      <= rows_d;
            bpr_q       <= bpr_d;
            row_addr_q  <= row_addr_d;
            req_off_q   <= req_off_d;
            req_row_q   <= req_row_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_len_q   <= req_len_d;
            beat_cnt_q  <= beat_cnt_d;
            row_cnt_q   <= row_cnt_d;
        end
    end
endmodule

// File: tb/tb_tile_row_fetcher.sv
// Scoreboard bench for tile_row_fetcher: a memory model answers read requests with a
// sequential data source, and a negedge monitor checks requests, beats and done pulses.
module tb_tile_row_fetcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_row_fetcher_if bus ();
    tile_row_fetcher dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [47:0] exp_req[$];   // {addr, len}
    logic [33:0] exp_beat[$];  // {data, row_last, tile_last}
    logic [31:0] mem_q[$];
    int          mem_seq  = 0;
    int          exp_seq  = 0;
    int          req_cnt  = 0;
    int          done_cnt = 0;
    bit          out_toggle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Monitor and memory model: handshakes complete at the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            mem_q.delete();
            mem_seq = 0;
        end else begin
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                req_cnt++;
                if (exp_req.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL req_unexpected: actual addr %0h len %0d required none",
                             bus.rd_req_addr, bus.rd_req_len);
                end else begin
                    check("req_addr_len", {bus.rd_req_addr, bus.rd_req_len}, exp_req.pop_front());
                end
                for (int k = 0; k < int'(bus.rd_req_len) / 4; k++) begin
                    mem_q.push_back(mem_seq);
                    mem_seq++;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_beat.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: actual data %0h required none", bus.out_data);
                end else begin
                    check("out_beat", {bus.out_data, bus.out_row_last, bus.out_tile_last},
                          exp_beat.pop_front());
                end
                if (mem_q.size() != 0) void'(mem_q.pop_front());
            end
            if (bus.busy && !bus.done) begin
                check("data_passthrough", {bus.rd_data_ready, bus.out_valid},
                      {bus.out_ready, bus.rd_data_valid});
            end else begin
                check("data_gated", {bus.rd_data_ready, bus.out_valid}, 2'b00);
            end
            if (bus.done) done_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        bus.out_ready     = out_toggle ? ~bus.out_ready : 1'b1;
        bus.rd_data_valid = (mem_q.size() != 0);
        bus.rd_data       = (mem_q.size() != 0) ? mem_q[0] : 32'h0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] addr, input logic [15:0] len);
        exp_req.push_back({addr, len});
    endtask

    task automatic push_beats(input int rows_now, input int rows_total, input int bpr);
        for (int r = 0; r < rows_now; r++) begin
            for (int b = 0; b < bpr; b++) begin
                exp_beat.push_back({exp_seq[31:0], b == bpr - 1,
                                    (b == bpr - 1) && (r == rows_total - 1)});
                exp_seq++;
            end
        end
    endtask

    task automatic issue(input logic [31:0] base, input logic [15:0] stride,
                         input logic [15:0] rb, input logic [15:0] rows);
        bus.cmd_valid        = 1'b1;
        bus.cmd_base_addr    = base;
        bus.cmd_stride_bytes = stride;
        bus.cmd_row_bytes    = rb;
        bus.cmd_rows         = rows;
        step();
        bus.cmd_valid        = 1'b0;
        bus.cmd_base_addr    = 32'hDEAD_BEEF;
        bus.cmd_row_bytes    = 16'hFFFF;
        bus.cmd_rows         = 16'hFFFF;
    endtask

    task automatic finish_cmd(input string name, input int d0);
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt != d0) break;
            step();
        end
        check({name, "_finished"}, done_cnt != d0, 1'b1);
        repeat (3) step();
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_req_left"}, exp_req.size(), 0);
        check({name, "_beat_left"}, exp_beat.size(), 0);
        check({name, "_idle"}, {bus.cmd_ready, bus.busy}, 2'b10);
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {bus.cmd_ready, bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_len,
                     bus.rd_data_ready, bus.out_valid, bus.out_row_last, bus.out_tile_last,
                     bus.busy, bus.done}, {1'b1, 55'h0});
    endtask

    task automatic zero_cmd(input string name, input logic [15:0] rb, input logic [15:0] rows);
        int d0 = done_cnt;
        int r0 = req_cnt;
        issue(32'h4000, 16'h100, rb, rows);
        check({name, "_t1"}, {bus.busy, bus.done, bus.rd_req_valid, bus.cmd_ready}, 4'b1100);
        step();
        check({name, "_t2"}, {bus.busy, bus.done, bus.rd_req_valid, bus.cmd_ready}, 4'b0001);
        step();
        check({name, "_counts"}, {req_cnt - r0, done_cnt - d0}, {32'd0, 32'd1});
    endtask

    task automatic run_basic(input string name);
        int d0 = done_cnt;
        push_req(32'h1000, 16); push_req(32'h1400, 16); push_req(32'h1800, 16);
        push_beats(3, 3, 4);
        issue(32'h1000, 16'h400, 16, 3);
        finish_cmd(name, d0);
    endtask

    initial begin
        int d0;
        int r0;
        bus.cmd_valid        = 1'b0;
        bus.cmd_base_addr    = '0;
        bus.cmd_stride_bytes = '0;
        bus.cmd_row_bytes    = '0;
        bus.cmd_rows         = '0;
        bus.rd_req_ready     = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        check_reset_vals("reset_values");

        run_basic("basic");

        d0 = done_cnt;
        push_req(32'h0, 256); push_req(32'h100, 256); push_req(32'h200, 88);
        push_req(32'h1000, 256); push_req(32'h1100, 256); push_req(32'h1200, 88);
        push_beats(2, 2, 150);
        issue(32'h0, 16'h1000, 600, 2);
        finish_cmd("chunking", d0);

        zero_cmd("zero_rows", 16, 0);
        zero_cmd("zero_rb", 3, 5);

        // Request held under backpressure, then downstream ready toggles every cycle.
        d0 = done_cnt;
        bus.rd_req_ready = 1'b0;
        push_req(32'h2000, 32); push_req(32'h2040, 32);
        push_beats(2, 2, 8);
        issue(32'h2000, 16'h40, 32, 2);
        for (int i = 0; i < 5; i++) begin
            check("stall_hold", {bus.rd_req_valid, bus.rd_req_addr, bus.rd_req_len},
                  {1'b1, 32'h2000, 16'd32});
            step();
        end
        bus.rd_req_ready = 1'b1;
        out_toggle = 1'b1;
        finish_cmd("backpressure", d0);
        out_toggle = 1'b0;

        d0 = done_cnt;
        push_req(32'hFFFF_FF00, 64); push_req(32'h0, 64);
        push_beats(2, 2, 16);
        issue(32'hFFFF_FF00, 16'h100, 64, 2);
        finish_cmd("wrap", d0);

        // Reset after two accepted requests; in-flight beats are discarded.
        r0 = req_cnt;
        push_req(32'h3000, 32); push_req(32'h3100, 32);
        push_beats(2, 8, 8);
        issue(32'h3000, 16'h100, 32, 8);
        for (int i = 0; i < 50; i++) begin
            if (req_cnt - r0 >= 2) break;
            step();
        end
        check("mid_reset_reqs", req_cnt - r0, 2);
        rst = 1'b1;
        bus.rd_req_ready = 1'b0;
        step();
        check_reset_vals("mid_reset_values");
        rst = 1'b0;
        bus.rd_req_ready = 1'b1;
        exp_req.delete();
        exp_beat.delete();
        exp_seq = 0;
        run_basic("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tile_row_fetcher.md
# tile_row_fetcher

Strided tile fetch engine that consumes a region descriptor (base address, row stride, row length, row count) of the kind produced by the address generator and turns it into memory read bursts, one or more per row. It then streams the returned data beats to the downstream motion/reference tile buffer, tagged with row and tile boundaries. It sits between the address generator and the memory read port on one side, and the tile buffer on the other.

## Interface
- ADDR_WIDTH, 32, address width in bits.
- DIM_WIDTH, 16, width of stride, row-byte, row-count and length fields.
- DATA_WIDTH, 32, read data width; BPB = DATA_WIDTH/8 bytes per beat (power of two).
- MAX_BURST_BYTES, 256, maximum bytes per read request (multiple of BPB).

- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  descriptor valid.
- cmd_ready  out  1  descriptor accepted when high with cmd_valid.
- cmd_base_addr  in  ADDR_WIDTH  first byte of the region.
- cmd_stride_bytes  in  DIM_WIDTH  byte distance between row starts.
- cmd_row_bytes  in  DIM_WIDTH  bytes per row; low log2(BPB) bits ignored.
- cmd_rows  in  DIM_WIDTH  number of rows.
- rd_req_valid  out  1  read request valid.
- rd_req_ready  in  1  memory accepts request.
- rd_req_addr  out  ADDR_WIDTH  request byte address.
- rd_req_len  out  DIM_WIDTH  request length in bytes (multiple of BPB, 1..MAX_BURST_BYTES).
- rd_data_valid  in  1  in-order read data beat valid.
- rd_data_ready  out  1  beat accepted.
- rd_data  in  DATA_WIDTH  read data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  DATA_WIDTH  output data.
- out_row_last  out  1  final beat of a row.
- out_tile_last  out  1  final beat of the region.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the region is fully delivered.

## Operation
- The command is latched on the cmd_valid & cmd_ready handshake. The effective row length is rb = cmd_row_bytes rounded down to a BPB multiple.
- FSM states: IDLE, RUN (issuing requests), DRAIN (all requests issued, beats outstanding), DONE (single cycle).
- IDLE: cmd_ready=1. On handshake, go to RUN; if rb==0 or cmd_rows==0, go to DONE instead, with no requests issued.
- Request side (RUN):
  - Per row, issue chunks of min(MAX_BURST_BYTES, remaining) at row_addr+offset.
  - row_addr starts at base and is incremented by stride after each row's final chunk.
  - Address arithmetic is modulo 2^ADDR_WIDTH (wraps).
  - After the last chunk of the last row is accepted, go to DRAIN.
- Data side (RUN and DRAIN):
  - Combinational passthrough: out_valid = rd_data_valid, rd_data_ready = out_ready, out_data = rd_data.
  - Outside RUN/DRAIN, rd_data_ready=0 and out_valid=0.
  - A beat counter tracks rb/BPB beats per row and a row counter tracks the row index.
  - out_row_last is high on each row's final beat; out_tile_last is high on the final beat of the final row.
  - Beats may arrive while requests are still being issued.
- On the out handshake with out_tile_last, go to DONE. DONE asserts done=1 for one cycle, then IDLE.
- busy=1 in RUN, DRAIN and DONE.
- Descriptor inputs are ignored outside the IDLE handshake.

## Timing
- Reset values: cmd_ready=1 after reset release (IDLE); rd_req_valid=0, rd_req_addr=0, rd_req_len=0, rd_data_ready=0, out_valid=0, out_row_last=0, out_tile_last=0, busy=0, done=0.
- Request outputs are registered.
  - First rd_req_valid appears in cycle T+1 after command handshake cycle T.
  - rd_req_addr and rd_req_len are held stable while rd_req_valid & !rd_req_ready.
  - After a request handshake at cycle t, the next request is valid at t+1 (back-to-back, one request per cycle max).
- Data path has zero latency; out_row_last and out_tile_last are combinational from the counters, valid with out_valid.
- done is high in the cycle after the final beat handshake. cmd_ready returns to 1 in the cycle after done.
- Zero-size command: done is high in T+1.
- rst mid-operation: next cycle, all state returns to reset values and in-flight beats are dropped. The memory side must be reset together.

## Test plan
- Basic: base 0x1000, stride 0x400, row_bytes 16, rows 3 -> requests (0x1000,16), (0x1400,16), (0x1800,16); 12 beats out; row_last on beats 4, 8, 12; tile_last on beat 12; one done pulse.
- Chunking: base 0x0, stride 0x1000, row_bytes 600, rows 2 -> requests (0x0,256), (0x100,256), (0x200,88), (0x1000,256), (0x1100,256), (0x1200,88); row_last on beats 150 and 300.
- Zero size: rows=0 or row_bytes=3 -> no rd_req_valid, done in cycle after accept, busy high for exactly that cycle.
- Backpressure: rd_req_ready low 5 cycles -> addr/len stable throughout. out_ready toggling -> rd_data_ready mirrors it, no beat lost or duplicated, final data matches a sequential source.
- Wrap: base 0xFFFFFF00, stride 0x100, row_bytes 64, rows 2 -> second request address 0x00000000.
- Reset mid-RUN after 2 requests -> all outputs at reset values next cycle; a new command then completes normally.
